// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction decoder:
// field widths, opcode values, loader FSM state encoding and an opcode
// legality helper.
package prog_loader_pkg;

    localparam int OPBTS  = 5;
    localparam int OPRBTS = 11;

    localparam logic [OPBTS-1:0] HLT  = 5'b00000;
    localparam logic [OPBTS-1:0] STO  = 5'b00001;
    localparam logic [OPBTS-1:0] LD   = 5'b00010;
    localparam logic [OPBTS-1:0] LDI  = 5'b00011;
    localparam logic [OPBTS-1:0] ADD  = 5'b00100;
    localparam logic [OPBTS-1:0] ADDI = 5'b00101;
    localparam logic [OPBTS-1:0] SUB  = 5'b00110;
    localparam logic [OPBTS-1:0] SUBI = 5'b00111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIGH  = 3'd1,
        LOW   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Any opcode above the last defined instruction is not executable.
    function automatic logic opcode_illegal(input logic [OPBTS-1:0] op);
        return (op > SUBI);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: assembles pairs of received bytes (high byte first) into
// 16-bit instruction words and writes them to program memory at consecutive
// addresses starting from 0. A load ends on a HLT word or after the word at
// the top address has been written; the address never wraps.
// Optional build macro PROG_LOADER_OPCHECK_EN: reject opcodes above SUBI,
// flag o_err, skip the write and end the load.
module prog_loader #(
    parameter int OPBTS   = prog_loader_pkg::OPBTS,
    parameter int OPRBTS  = prog_loader_pkg::OPRBTS,
    parameter int ADDRBTS = 11
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_wr_en,
    output logic [ADDRBTS-1:0]       o_wr_addr,
    output logic [OPBTS+OPRBTS-1:0]  o_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    import prog_loader_pkg::*;

    localparam int                 WORD_W   = OPBTS + OPRBTS;
    localparam logic [ADDRBTS-1:0] ADDR_MAX = {ADDRBTS{1'b1}};
    localparam logic [ADDRBTS-1:0] ADDR_ONE = {{(ADDRBTS-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_n_s;
    logic [ADDRBTS-1:0]  addr_r;
    logic [WORD_W-1:0]   word_r;
    logic                wr_en_r;
    logic                busy_r;
    logic                done_r;
    logic                start_s;
    logic                last_s;
    logic                bad_word_s;

    // A start only counts when the loader is idle; in every other state it is ignored.
    assign start_s = (state_r == IDLE) && i_start;

    // Final word of a load: a HLT, or the top of the address space.
    assign last_s = (word_r[WORD_W-1 -: OPBTS] == HLT) || (addr_r == ADDR_MAX);

`ifdef PROG_LOADER_OPCHECK_EN
    logic err_r;

    // Illegal-opcode flag: set by a bad high byte, sticky until the next accepted start.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            err_r <= 1'b0;
        end else if (start_s) begin
            err_r <= 1'b0;
        end else if ((state_r == HIGH) && i_rx_valid && opcode_illegal(i_rx_data[7 -: OPBTS])) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bad_word_s = err_r;
    assign o_err      = err_r;
`else
    assign bad_word_s = 1'b0;
    assign o_err      = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic: bytes advance HIGH->LOW->WRITE; WRITE loops or finishes.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_n_s = HIGH;
                end else begin
                    state_n_s = IDLE;
                end
            end
            HIGH: begin
                if (i_rx_valid) begin
                    state_n_s = LOW;
                end else begin
                    state_n_s = HIGH;
                end
            end
            LOW: begin
                if (i_rx_valid && bad_word_s) begin
                    state_n_s = DONE;
                end else if (i_rx_valid) begin
                    state_n_s = WRITE;
                end else begin
                    state_n_s = LOW;
                end
            end
            WRITE: begin
                if (last_s) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = HIGH;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Byte assembly: high byte lands in the upper half, low byte in the lower half.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_r <= {WORD_W{1'b0}};
        end else if ((state_r == HIGH) && i_rx_valid) begin
            word_r[WORD_W-1 -: 8] <= i_rx_data;
        end else if ((state_r == LOW) && i_rx_valid) begin
            word_r[7:0] <= i_rx_data;
        end else begin
            word_r <= word_r;
        end
    end

    // Address counter: cleared by a start, advanced only when another word follows.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr_r <= {ADDRBTS{1'b0}};
        end else if (start_s) begin
            addr_r <= {ADDRBTS{1'b0}};
        end else if ((state_r == WRITE) && !last_s) begin
            addr_r <= addr_r + ADDR_ONE;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Registered status and strobe outputs, aligned with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wr_en_r <= (state_n_s == WRITE);
            busy_r  <= (state_n_s == HIGH) || (state_n_s == LOW) || (state_n_s == WRITE);
            if (start_s) begin
                done_r <= 1'b0;
            end else if (state_n_s == DONE) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    assign o_wr_en   = wr_en_r;
    assign o_wr_addr = addr_r;
    assign o_wr_data = word_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes into a
// queue per instance, monitors pop and compare on every o_wr_en. A second
// instance with ADDRBTS=2 exercises the end-of-memory stop.
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [7:0]  rx_data0, rx_data1;
    logic        rx_valid0, rx_valid1;

    logic        wr_en0, busy0, done0, err0;
    logic [10:0] wr_addr0;
    logic [15:0] wr_data0;
    logic        wr_en1, busy1, done1, err1;
    logic [1:0]  wr_addr1;
    logic [15:0] wr_data1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    prog_loader dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start0),
        .i_rx_data(rx_data0), .i_rx_valid(rx_valid0),
        .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
        .o_busy(busy0), .o_done(done0), .o_err(err0)
    );

    prog_loader #(.ADDRBTS(2)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start1),
        .i_rx_data(rx_data1), .i_rx_valid(rx_valid1),
        .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
        .o_busy(busy1), .o_done(done1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (wr_en0) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected write", {5'd0, wr_addr0, wr_data0}, 32'hFFFF_FFFF);
            end else begin
                check("dut0 write addr/data", {5'd0, wr_addr0, wr_data0}, q0.pop_front());
                check("dut0 busy during write", {31'd0, busy0}, 32'd1);
            end
        end
    end

    // Monitor for the ADDRBTS=2 instance.
    always @(negedge clk) begin
        if (wr_en1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected write", {14'd0, wr_addr1, wr_data1}, 32'hFFFF_FFFF);
            end else begin
                check("dut1 write addr/data", {14'd0, wr_addr1, wr_data1}, q1.pop_front());
            end
        end
    end

    task automatic send_byte(input bit which, input logic [7:0] b);
        @(negedge clk);
        if (which) begin rx_data1 = b; rx_valid1 = 1'b1; end
        else       begin rx_data0 = b; rx_valid0 = 1'b1; end
        @(negedge clk);
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1;
        else       start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Sends one word; when a write is expected it is queued before the low
    // byte and the strobe is checked one cycle after the low byte.
    task automatic send_word(input bit which, input logic [7:0] hi, input logic [7:0] lo,
                             input bit expect_wr, input logic [10:0] addr);
        send_byte(which, hi);
        if (expect_wr) begin
            if (which) q1.push_back({5'd0, addr, hi, lo});
            else       q0.push_back({5'd0, addr, hi, lo});
        end
        send_byte(which, lo);
        if (expect_wr) begin
            check("write latency", {31'd0, (which ? wr_en1 : wr_en0)}, 32'd1);
        end
    endtask

    task automatic check_finished(input string name);
        @(negedge clk);
        check({name, " done"}, {31'd0, done0}, 32'd1);
        check({name, " busy"}, {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        rx_data0 = 8'h00; rx_data1 = 8'h00;
        rx_valid0 = 1'b0; rx_valid1 = 1'b0;
        #12;
        check("reset outputs", {wr_en0, busy0, done0, err0, 5'd0, wr_addr0, wr_data0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte while idle is ignored.
        send_byte(1'b0, 8'h08);
        @(negedge clk);
        check("idle byte ignored busy", {31'd0, busy0}, 32'd0);

        // STO 5 then HLT.
        pulse_start(1'b0);
        check("busy after start", {31'd0, busy0}, 32'd1);
        send_word(1'b0, 8'h08, 8'h05, 1'b1, 11'd0);
        send_word(1'b0, 8'h00, 8'h00, 1'b1, 11'd1);
        check_finished("sto+hlt");
        @(negedge clk);
        check("done held in idle", {31'd0, done0}, 32'd1);

        // LDI 3 (start pulsed mid-word), ADD 1, HLT.
        pulse_start(1'b0);
        check("done cleared by start", {31'd0, done0}, 32'd0);
        send_byte(1'b0, 8'h18);
        q0.push_back({5'd0, 11'd0, 16'h1803});
        pulse_start(1'b0);
        send_byte(1'b0, 8'h03);
        send_word(1'b0, 8'h20, 8'h01, 1'b1, 11'd1);
        send_word(1'b0, 8'h00, 8'h00, 1'b1, 11'd2);
        check_finished("three words");

        // Reset after the high byte of the second word aborts the load.
        pulse_start(1'b0);
        send_word(1'b0, 8'h08, 8'h05, 1'b1, 11'd0);
        send_byte(1'b0, 8'h20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-load reset outputs", {wr_en0, busy0, done0, err0, 5'd0, wr_addr0, wr_data0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(1'b0, 8'h01);
        repeat (3) @(negedge clk);
        check("no busy after abort", {31'd0, busy0}, 32'd0);
        pulse_start(1'b0);
        send_word(1'b0, 8'h08, 8'h07, 1'b1, 11'd0);

        // A byte arriving in WRITE is lost; the next word is still a clean HLT.
        send_byte(1'b0, 8'h10);
        q0.push_back({5'd0, 11'd1, 16'h1022});
        send_byte(1'b0, 8'h22);
        rx_data0 = 8'h55; rx_valid0 = 1'b1;
        @(negedge clk);
        rx_valid0 = 1'b0;
        check("byte in write lost busy", {31'd0, busy0}, 32'd1);
        send_word(1'b0, 8'h00, 8'h00, 1'b1, 11'd2);
        check_finished("lost byte");

        // Opcode 01000.
        pulse_start(1'b0);
`ifdef PROG_LOADER_OPCHECK_EN
        send_byte(1'b0, 8'h40);
        check("err set by bad opcode", {31'd0, err0}, 32'd1);
        send_byte(1'b0, 8'h00);
        check("bad opcode done", {31'd0, done0}, 32'd1);
        check("bad opcode busy", {31'd0, busy0}, 32'd0);
`else
        send_word(1'b0, 8'h40, 8'h00, 1'b1, 11'd0);
        check("err tied low", {31'd0, err0}, 32'd0);
        send_word(1'b0, 8'h00, 8'h00, 1'b1, 11'd1);
        check_finished("unchecked opcode");
`endif

        // ADDRBTS=2: only addresses 0..3, fifth word ignored.
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            send_word(1'b1, 8'h08, 8'(k + 1), 1'b1, 11'(k));
        end
        @(negedge clk);
        check("top address done", {31'd0, done1}, 32'd1);
        check("top address busy", {31'd0, busy1}, 32'd0);
        send_word(1'b1, 8'h08, 8'h05, 1'b0, 11'd0);
        repeat (2) @(negedge clk);
        check("fifth word ignored busy", {31'd0, busy1}, 32'd0);
        check("fifth word done held", {31'd0, done1}, 32'd1);

        repeat (2) @(negedge clk);
        check("dut0 queue drained", q0.size(), 32'd0);
        check("dut1 queue drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter OPBTS, default 5, SHALL set the opcode field width.
REQ-002 Parameter OPRBTS, default 11, SHALL set the operand field width; the instruction word is OPBTS+OPRBTS = 16 bits.
REQ-003 Parameter ADDRBTS, default 11, SHALL set the program-memory address width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_rst  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  one-cycle pulse that begins a load.
REQ-008 i_rx_data  input  8  received byte.
REQ-009 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-010 o_wr_en  output  1  program-memory write strobe.
REQ-011 o_wr_addr  output  ADDRBTS  write address.
REQ-012 o_wr_data  output  16  instruction word {opcode, operand}.
REQ-013 o_busy  output  1  high while a load is in progress.
REQ-014 o_done  output  1  high once a load has completed; held until the next i_start.
REQ-015 o_err  output  1  illegal-opcode flag; sticky until the next i_start.

Function
REQ-016 The FSM SHALL have the states IDLE, HIGH, LOW, WRITE and DONE.
REQ-017 In IDLE, an i_start pulse SHALL move the FSM to HIGH, clear the address counter to 0, and clear o_done and o_err.
REQ-018 In HIGH, a byte with i_rx_valid SHALL be latched as word bits [15:8] (opcode in bits [15:11]), and the FSM SHALL move to LOW.
REQ-019 In LOW, a byte with i_rx_valid SHALL be latched as word bits [7:0], and the FSM SHALL move to WRITE.
REQ-020 In WRITE, the block SHALL assert o_wr_en for exactly one cycle, with o_wr_addr equal to the counter and o_wr_data equal to the assembled word.
REQ-021 After WRITE, if the opcode is HLT (00000) or the address is 2^ADDRBTS-1, the FSM SHALL go to DONE; otherwise it SHALL increment the address and return to HIGH.
REQ-022 Latency SHALL be 1 cycle from the i_rx_valid of the low byte to o_wr_en.
REQ-023 i_rx_valid SHALL be ignored in IDLE, WRITE and DONE; a byte arriving in WRITE is lost.
REQ-024 i_start SHALL be ignored while o_busy is high.
REQ-025 In DONE, the block SHALL assert o_done, deassert o_busy, and return to IDLE in the next cycle; o_done stays held.
REQ-026 o_busy SHALL be high in the HIGH, LOW and WRITE states.
REQ-027 o_wr_addr SHALL never wrap; the word at 2^ADDRBTS-1 is the last word written.

Reset
REQ-028 Asserting i_rst low SHALL asynchronously force: state IDLE, address 0, o_wr_en=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0.
REQ-029 A reset mid-load SHALL abort the load with no further write; words already written stay written.
REQ-030 Reset release SHALL take effect on the next rising edge of i_clk.

Configuration
REQ-031 With macro PROG_LOADER_OPCHECK_EN defined, a high byte whose opcode is greater than 00111 SHALL set o_err, suppress the write for that word, and send the FSM to DONE once the low byte is received.
REQ-032 Without PROG_LOADER_OPCHECK_EN, opcodes SHALL NOT be checked; o_err SHALL be tied to 0 and every word is written.

Structure
REQ-033 Opcode localparams (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI), OPBTS, OPRBTS and the FSM state encoding SHALL live in a shared package/include common to the decoder and the loader.
REQ-034 The block SHALL be a single module with no sub-modules; the address counter and byte assembly are inline.

Verification
REQ-035 Reset, then i_start, then bytes 0x08,0x05 (STO 5) -> o_wr_en one cycle later with addr 0 and data 0x0805; o_busy=1.
REQ-036 Three words LDI 3 (0x18,0x03), ADD 1 (0x20,0x01), HLT (0x00,0x00) -> writes at addresses 0,1,2, then o_done=1 and o_busy=0.
REQ-037 i_rst pulsed low after the high byte of the second word -> no second write; outputs equal reset values; a new i_start restarts the load at address 0.
REQ-038 With PROG_LOADER_OPCHECK_EN, bytes 0x40,0x00 (opcode 01000) -> o_err=1, no o_wr_en, o_done=1; without the macro -> word written and o_err=0.
REQ-039 With ADDRBTS=2, five non-HLT words -> writes at addresses 0..3 only, o_done after the fourth write, fifth word ignored.
REQ-040 i_rx_valid pulsed while in IDLE, and i_start pulsed mid-load -> no state change and no write.
